// File: rtl/borrow_skip_subtractor_seq.sv
// Multi-cycle subtractor: diff = a - b - bin, one BLOCK_W-bit block per clock,
// LSB first, with a borrow-skip bypass across each block.
module borrow_skip_subtractor_seq #(
  parameter int unsigned WIDTH   = 64,
  parameter int unsigned BLOCK_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NBLK  = WIDTH / BLOCK_W;
  localparam int unsigned CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               br;
  logic [CNT_W-1:0]   cnt;

  int unsigned        base;
  logic [BLOCK_W-1:0] a_blk;
  logic [BLOCK_W-1:0] b_blk;
  logic [BLOCK_W-1:0] d_blk;
  logic               ripple_br;
  logic               blk_p;
  logic               blk_bout;
  logic [WIDTH-1:0]   diff_upd;

  // Current block: ripple borrow chain plus skip mux on the block borrow-out.
  always_comb begin
    base      = 32'(cnt) * BLOCK_W;
    a_blk     = a_q[base +: BLOCK_W];
    b_blk     = b_q[base +: BLOCK_W];
    d_blk     = '0;
    ripple_br = br;
    for (int i = 0; i < int'(BLOCK_W); i++) begin
      d_blk[i]  = a_blk[i] ^ b_blk[i] ^ ripple_br;
      ripple_br = (~a_blk[i] & b_blk[i]) | (~(a_blk[i] ^ b_blk[i]) & ripple_br);
    end
    blk_p    = &(~(a_blk ^ b_blk));
    blk_bout = blk_p ? br : ripple_br;
    diff_upd = diff;
    diff_upd[base +: BLOCK_W] = d_blk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      br        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a;
            b_q      <= b;
            br       <= bin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          diff <= diff_upd;
          br   <= blk_bout;
          if (cnt == CNT_W'(NBLK - 1)) begin
            // Flags are formed from the fully updated difference on the last block edge.
            bout      <= blk_bout;
            ovf       <= (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_upd[WIDTH-1] ^ a_q[WIDTH-1]);
            zero      <= ~|diff_upd;
            out_valid <= 1'b1;
            cnt       <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_borrow_skip_subtractor_seq.sv
// Self-checking bench for borrow_skip_subtractor_seq: directed vectors plus
// randomized handshakes against a 65-bit arithmetic model.
module tb_borrow_skip_subtractor_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  int checks   = 0;
  int failures = 0;

  borrow_skip_subtractor_seq #(.WIDTH(64), .BLOCK_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .ovf(ovf), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one request, check latency, outputs and output handshake.
  task automatic run_op(input string tag, input logic [63:0] va, input logic [63:0] vb,
                        input logic vbin, input logic [63:0] e_diff, input logic e_bout,
                        input logic e_ovf, input logic e_zero);
    int n;
    check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    a = va; b = vb; bin = vbin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a = ~va; b = ~vb; bin = ~vbin;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd8);
    check({tag, "_diff"}, diff, e_diff);
    check({tag, "_bout"}, 64'(bout), 64'(e_bout));
    check({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
    check({tag, "_zero"}, 64'(zero), 64'(e_zero));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_ir_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] sd;
    logic        sb, so, sz;
    logic [64:0] gold;
    logic        acc, hs, seen;
    int          n;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_diff", diff, 64'd0);
    check("rst_flags", {61'd0, bout, ovf, zero}, 64'd0);

    run_op("basic", 64'd10, 64'd3, 1'b0, 64'd7, 1'b0, 1'b0, 1'b0);
    run_op("underflow", 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("sovf", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);
    run_op("skip_bin1", 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    run_op("skip_bin0", 64'h5555_5555_5555_5555, 64'h5555_5555_5555_5555, 1'b0,
           64'd0, 1'b0, 1'b0, 1'b1);
    run_op("mixed", 64'h0123_4567_89AB_CDEF, 64'h0023_0067_00AB_00EF, 1'b1,
           64'h0100_4500_8900_CCFF, 1'b0, 1'b0, 1'b0);

    // Backpressure with in_valid held high and inputs changing throughout.
    a = 64'd100; b = 64'd58; bin = 1'b1; in_valid = 1'b1;
    tick();
    a = 64'd1; b = 64'd2;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("bp_latency", 64'(n), 64'd8);
    for (int i = 0; i < 5; i++) begin
      a = 64'(i); b = 64'(i * 7);
      tick();
      check("bp_diff_hold", diff, 64'd41);
      check("bp_ov_hold", 64'(out_valid), 64'd1);
      check("bp_ir_low", 64'(in_ready), 64'd0);
      check("bp_flags_hold", {61'd0, bout, ovf, zero}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp_ov_drop", 64'(out_valid), 64'd0);
    check("bp_ir_back", 64'(in_ready), 64'd1);

    // Reset in the middle of an operation.
    a = 64'd9; b = 64'd4; bin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_in_ready", 64'(in_ready), 64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_diff", diff, 64'd0);
    tick();
    check("abort_stays_idle", 64'(out_valid), 64'd0);

    // Random vectors with random in_valid / out_ready timing.
    for (int t = 0; t < 2000; t++) begin
      logic [63:0] ra, rb;
      logic        rbin;
      ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; rbin = 1'($urandom_range(0, 1));
      case (t % 8)
        0: rb = ra;
        1: ra = 64'd0;
        2: rb = 64'hFFFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      gold = {1'b0, ra} - {1'b0, rb} - 65'(rbin);
      sd = gold[63:0];
      sb = gold[64];
      so = (ra[63] ^ rb[63]) & (sd[63] ^ ra[63]);
      sz = (sd == 64'd0);
      n = 0;
      acc = 1'b0;
      while (!acc && n < 50) begin
        a = ra; b = rb; bin = rbin;
        in_valid = 1'($urandom_range(0, 1));
        acc = in_valid && in_ready;
        tick();
        n++;
      end
      if (!acc) check("rnd_accept_timeout", 64'd0, 64'd1);
      n = 0;
      hs = 1'b0;
      seen = 1'b0;
      while (!hs && n < 50) begin
        in_valid = 1'($urandom_range(0, 1));
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; bin = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && !seen) begin
          seen = 1'b1;
          check("rnd_diff", diff, sd);
          check("rnd_flags", {61'd0, bout, ovf, zero}, {61'd0, sb, so, sz});
        end
        hs = out_valid && out_ready;
        tick();
        n++;
      end
      if (!hs) check("rnd_result_timeout", 64'd0, 64'd1);
      out_ready = 1'b0;
      check("rnd_ov_drop", 64'(out_valid), 64'd0);
    end
    in_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
